// File: rtl/conv_pkg.sv
// Shared types for the conv tile scheduler: FSM state encoding, latched layer config
// and the zero-field check used to reject an unusable layer.
package conv_pkg;

    localparam int DIM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WB,
        S_DONE
    } conv_sched_state_t;

    typedef struct packed {
        logic [DIM_W-1:0] nif;
        logic [DIM_W-1:0] nky;
        logic [DIM_W-1:0] nkx;
        logic [DIM_W-1:0] nof;
        logic [DIM_W-1:0] noy;
        logic [DIM_W-1:0] nox;
        logic [DIM_W-1:0] s;
    } conv_cfg_t;

    function automatic logic cfg_has_zero(input conv_cfg_t c);
        return (c.nif == '0) || (c.nky == '0) || (c.nkx == '0) ||
               (c.nof == '0) || (c.noy == '0) || (c.nox == '0) || (c.s == '0);
    endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// MAC-beat and tile-writeback handshake bundle between the scheduler (master)
// and the MAC array / writeback path (slave).
interface conv_tile_scheduler_if #(
    parameter int DIM_W = conv_pkg::DIM_W
);
    logic               op_valid;
    logic               op_ready;
    logic [DIM_W-1:0]   op_ni;
    logic [DIM_W-1:0]   op_ky;
    logic [DIM_W-1:0]   op_kx;
    logic [DIM_W-1:0]   op_of_base;
    logic [DIM_W-1:0]   op_oy_base;
    logic [DIM_W-1:0]   op_ox_base;
    logic [2*DIM_W-1:0] op_ifm_x;
    logic [2*DIM_W-1:0] op_ifm_y;
    logic               op_acc_clr;
    logic               op_acc_last;
    logic               wb_valid;
    logic               wb_ready;

    modport master (
        output op_valid, op_ni, op_ky, op_kx, op_of_base, op_oy_base, op_ox_base,
               op_ifm_x, op_ifm_y, op_acc_clr, op_acc_last, wb_valid,
        input  op_ready, wb_ready
    );

    modport slave (
        input  op_valid, op_ni, op_ky, op_kx, op_of_base, op_oy_base, op_ox_base,
               op_ifm_x, op_ifm_y, op_acc_clr, op_acc_last, wb_valid,
        output op_ready, wb_ready
    );
endinterface

// File: rtl/conv_loop_counter.sv
// One level of the loop nest: advances by step on inc and returns to 0 (raising wrap)
// once value+step would reach limit, so a partial last step is still visited.
module conv_loop_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);
    // One extra bit so value+step cannot alias past the limit
    logic [W:0] next_sum;

    assign next_sum = {1'b0, value} + {1'b0, step};
    assign wrap     = inc && (next_sum >= {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : next_sum[W-1:0];
        end
    end
endmodule

// File: rtl/conv_tile_scheduler.sv
// Conv layer loop-nest sequencer: tiles (of,oy,ox) outer, beats (ni,ky,kx) inner.
// Optional stall counter enabled by defining CONV_PERF_CNT_EN.
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int POF = 8,
    parameter int POY = 4,
    parameter int POX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] cfg_nif,
    input  logic [DIM_W-1:0] cfg_nky,
    input  logic [DIM_W-1:0] cfg_nkx,
    input  logic [DIM_W-1:0] cfg_nof,
    input  logic [DIM_W-1:0] cfg_noy,
    input  logic [DIM_W-1:0] cfg_nox,
    input  logic [DIM_W-1:0] cfg_s,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [31:0]      perf_stall,
    conv_tile_scheduler_if.master bus
);
    localparam logic [DIM_W-1:0] STEP_1 = DIM_W'(1);
    localparam logic [DIM_W-1:0] STEP_F = DIM_W'(POF);
    localparam logic [DIM_W-1:0] STEP_Y = DIM_W'(POY);
    localparam logic [DIM_W-1:0] STEP_X = DIM_W'(POX);

    conv_sched_state_t state;
    conv_cfg_t         cfg;
    conv_cfg_t         cfg_in;

    logic start_acc, abort_hit, cnt_clr, beat_fire, tile_fire;
    logic [DIM_W-1:0] kx_val, ky_val, ni_val, ox_val, oy_val, of_val;
    logic kx_wrap, ky_wrap, ni_wrap, ox_wrap, oy_wrap, of_wrap;

    assign cfg_in    = '{nif: cfg_nif, nky: cfg_nky, nkx: cfg_nkx,
                         nof: cfg_nof, noy: cfg_noy, nox: cfg_nox, s: cfg_s};
    assign start_acc = start && (state == S_IDLE);
    assign abort_hit = abort && (state != S_IDLE);
    assign cnt_clr   = start_acc || abort_hit;
    assign beat_fire = bus.op_valid && bus.op_ready && !abort;
    assign tile_fire = bus.wb_valid && bus.wb_ready && !abort;

    // Inner chain: kx fastest, ni wrap marks the last beat of the tile
    conv_loop_counter #(.W(DIM_W)) u_kx (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(beat_fire),
        .step(STEP_1), .limit(cfg.nkx), .value(kx_val), .wrap(kx_wrap));
    conv_loop_counter #(.W(DIM_W)) u_ky (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(kx_wrap),
        .step(STEP_1), .limit(cfg.nky), .value(ky_val), .wrap(ky_wrap));
    conv_loop_counter #(.W(DIM_W)) u_ni (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(ky_wrap),
        .step(STEP_1), .limit(cfg.nif), .value(ni_val), .wrap(ni_wrap));

    // Outer chain: ox fastest, of wrap marks the last tile of the layer
    conv_loop_counter #(.W(DIM_W)) u_ox (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(tile_fire),
        .step(STEP_X), .limit(cfg.nox), .value(ox_val), .wrap(ox_wrap));
    conv_loop_counter #(.W(DIM_W)) u_oy (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(ox_wrap),
        .step(STEP_Y), .limit(cfg.noy), .value(oy_val), .wrap(oy_wrap));
    conv_loop_counter #(.W(DIM_W)) u_of (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(oy_wrap),
        .step(STEP_F), .limit(cfg.nof), .value(of_val), .wrap(of_wrap));

    assign bus.op_ni       = ni_val;
    assign bus.op_ky       = ky_val;
    assign bus.op_kx       = kx_val;
    assign bus.op_of_base  = of_val;
    assign bus.op_oy_base  = oy_val;
    assign bus.op_ox_base  = ox_val;
    assign bus.op_ifm_x    = {{DIM_W{1'b0}}, cfg.s} * {{DIM_W{1'b0}}, ox_val}
                           + {{DIM_W{1'b0}}, kx_val};
    assign bus.op_ifm_y    = {{DIM_W{1'b0}}, cfg.s} * {{DIM_W{1'b0}}, oy_val}
                           + {{DIM_W{1'b0}}, ky_val};
    assign bus.op_acc_clr  = bus.op_valid && (ni_val == '0) && (ky_val == '0) && (kx_val == '0);
    assign bus.op_acc_last = bus.op_valid && (ni_val == cfg.nif - STEP_1)
                           && (ky_val == cfg.nky - STEP_1) && (kx_val == cfg.nkx - STEP_1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cfg          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            bus.op_valid <= 1'b0;
            bus.wb_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (abort_hit) begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                bus.op_valid <= 1'b0;
                bus.wb_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cfg     <= cfg_in;
                            busy    <= 1'b1;
                            cfg_err <= cfg_has_zero(cfg_in);
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cfg_has_zero(cfg)) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            bus.op_valid <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (ni_wrap) begin
                            bus.op_valid <= 1'b0;
                            bus.wb_valid <= 1'b1;
                            state        <= S_WB;
                        end
                    end
                    S_WB: begin
                        if (tile_fire) begin
                            bus.wb_valid <= 1'b0;
                            if (of_wrap) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end else begin
                                bus.op_valid <= 1'b1;
                                state        <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CONV_PERF_CNT_EN
    logic stall;
    assign stall = (bus.op_valid && !bus.op_ready) || (bus.wb_valid && !bus.wb_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
        end else if (start_acc) begin
            perf_stall <= '0;
        end else if (stall && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: directed layers plus randomized
// throttling and configs against a loop-nest reference model.
module tb_conv_tile_scheduler;
    import conv_pkg::*;

    localparam int POF = 8;
    localparam int POY = 4;
    localparam int POX = 4;

    typedef struct packed {
        logic [7:0]  ni, ky, kx, ofb, oyb, oxb;
        logic [15:0] ifx, ify;
        logic        clr, last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, busy, done, cfg_err;
    logic [DIM_W-1:0] cfg_nif, cfg_nky, cfg_nkx, cfg_nof, cfg_noy, cfg_nox, cfg_s;
    logic [31:0] perf_stall;

    conv_tile_scheduler_if #(.DIM_W(DIM_W)) bus ();

    conv_tile_scheduler #(.POF(POF), .POY(POY), .POX(POX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_nif(cfg_nif), .cfg_nky(cfg_nky), .cfg_nkx(cfg_nkx),
        .cfg_nof(cfg_nof), .cfg_noy(cfg_noy), .cfg_nox(cfg_nox), .cfg_s(cfg_s),
        .busy(busy), .done(done), .cfg_err(cfg_err), .perf_stall(perf_stall),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [23:0] exp_t[$];
    logic [23:0] last_tile;
    int n_tiles;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.ni = bus.op_ni; b.ky = bus.op_ky; b.kx = bus.op_kx;
        b.ofb = bus.op_of_base; b.oyb = bus.op_oy_base; b.oxb = bus.op_ox_base;
        b.ifx = bus.op_ifm_x; b.ify = bus.op_ifm_y;
        b.clr = bus.op_acc_clr; b.last = bus.op_acc_last;
        return b;
    endfunction

    // Reference: plain nested loops over tiles then (ni,ky,kx)
    task automatic build_model(input int nif, nky, nkx, nof, noy, nox, s);
        beat_t b;
        exp_q.delete();
        exp_t.delete();
        for (int of = 0; of < nof; of += POF)
            for (int oy = 0; oy < noy; oy += POY)
                for (int ox = 0; ox < nox; ox += POX) begin
                    exp_t.push_back({8'(of), 8'(oy), 8'(ox)});
                    for (int ni = 0; ni < nif; ni++)
                        for (int ky = 0; ky < nky; ky++)
                            for (int kx = 0; kx < nkx; kx++) begin
                                b.ni = 8'(ni); b.ky = 8'(ky); b.kx = 8'(kx);
                                b.ofb = 8'(of); b.oyb = 8'(oy); b.oxb = 8'(ox);
                                b.ifx = 16'(s * ox + kx);
                                b.ify = 16'(s * oy + ky);
                                b.clr = (ni == 0) && (ky == 0) && (kx == 0);
                                b.last = (ni == nif - 1) && (ky == nky - 1) && (kx == nkx - 1);
                                exp_q.push_back(b);
                            end
                end
    endtask

    task automatic start_layer(input int nif, nky, nkx, nof, noy, nox, s);
        @(negedge clk);
        cfg_nif = 8'(nif); cfg_nky = 8'(nky); cfg_nkx = 8'(nkx);
        cfg_nof = 8'(nof); cfg_noy = 8'(noy); cfg_nox = 8'(nox); cfg_s = 8'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_layer(input int nif, nky, nkx, nof, noy, nox, s,
                             input int unsigned pct, input string tag);
        beat_t cur, e;
        logic [83:0] snap, now_s;
        bit hold = 0;
        bit fin = 0;
        int cyc = 2;
        int stalls = 0;
        int wb_cyc = -10;
        build_model(nif, nky, nkx, nof, noy, nox, s);
        obs_q.delete();
        n_tiles = 0;
        snap = '0;
        start_layer(nif, nky, nkx, nof, noy, nox, s);
        chk({tag, "_busy_after_start"}, 128'(busy), 128'(1));
        chk({tag, "_no_valid_in_check"}, 128'(bus.op_valid), 128'(0));
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cur = cur_beat();
            now_s = {bus.op_valid, bus.wb_valid, cur};
            if (cyc == 2) chk({tag, "_first_valid_latency"}, 128'(bus.op_valid), 128'(1));
            if (hold) chk({tag, "_stable_under_stall"}, 128'(now_s), 128'(snap));
            hold = 0;
            bus.op_ready = ($urandom_range(99) < pct);
            bus.wb_ready = ($urandom_range(99) < pct);
            if (done) begin
                fin = 1;
                chk({tag, "_done_after_wb"}, 128'(cyc), 128'(wb_cyc + 1));
                chk({tag, "_busy_low_at_done"}, 128'(busy), 128'(0));
                chk({tag, "_beats_left"}, 128'(exp_q.size()), 128'(0));
                chk({tag, "_tiles_left"}, 128'(exp_t.size()), 128'(0));
`ifdef CONV_PERF_CNT_EN
                chk({tag, "_perf_stall"}, 128'(perf_stall), 128'(stalls));
`else
                chk({tag, "_perf_stall"}, 128'(perf_stall), 128'(0));
`endif
            end else begin
                if (bus.op_valid) begin
                    if (bus.op_ready) begin
                        obs_q.push_back(cur);
                        if (exp_q.size() == 0) chk({tag, "_extra_beat"}, 128'(1), 128'(0));
                        else begin
                            e = exp_q.pop_front();
                            chk({tag, "_beat"}, 128'(cur), 128'(e));
                        end
                    end else begin
                        hold = 1;
                        stalls++;
                    end
                end
                if (bus.wb_valid) begin
                    if (bus.wb_ready) begin
                        last_tile = {cur.ofb, cur.oyb, cur.oxb};
                        n_tiles++;
                        wb_cyc = cyc;
                        if (exp_t.size() == 0) chk({tag, "_extra_tile"}, 128'(1), 128'(0));
                        else chk({tag, "_wb_tile"}, 128'(last_tile), 128'(exp_t.pop_front()));
                    end else begin
                        hold = 1;
                        stalls++;
                    end
                end
            end
            snap = now_s;
            cyc++;
        end
        if (!fin) chk({tag, "_timeout"}, 128'(0), 128'(1));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
    endtask

    initial begin
        int lasts;
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_nif = '0; cfg_nky = '0; cfg_nkx = '0; cfg_nof = '0; cfg_noy = '0;
        cfg_nox = '0; cfg_s = '0;
        bus.op_ready = 1'b0; bus.wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({busy, done, cfg_err, bus.op_valid, bus.wb_valid,
                                   cur_beat(), perf_stall}), 128'(0));
        rst_n = 1'b1;

        // Single beat, single tile
        run_layer(1, 1, 1, 8, 4, 4, 1, 100, "t1");
        chk("t1_beats", 128'(obs_q.size()), 128'(1));
        chk("t1_clr_last", 128'({obs_q[0].clr, obs_q[0].last}), 128'(2'b11));

        // 18 beats, kx fastest, stride 2
        run_layer(2, 3, 3, 8, 4, 4, 2, 100, "t2");
        chk("t2_beats", 128'(obs_q.size()), 128'(18));
        chk("t2_beat3", 128'({obs_q[3].ni, obs_q[3].ky, obs_q[3].kx, obs_q[3].ifx, obs_q[3].ify}),
            128'({8'd0, 8'd1, 8'd0, 16'd0, 16'd1}));
        lasts = 0;
        foreach (obs_q[i]) lasts += int'(obs_q[i].last);
        chk("t2_last_count", 128'(lasts), 128'(1));
        chk("t2_last_on_17", 128'(obs_q[17].last), 128'(1));

        // Multi-tile with partial last ox tile
        run_layer(1, 1, 1, 16, 8, 5, 1, 100, "t3");
        chk("t3_tiles", 128'(n_tiles), 128'(8));
        chk("t3_last_tile", 128'(last_tile), 128'({8'd8, 8'd4, 8'd4}));

        // Random throttling on the test-2 layer
        run_layer(2, 3, 3, 8, 4, 4, 2, 50, "t4");
        chk("t4_beats", 128'(obs_q.size()), 128'(18));

        // Random layers and throttling
        for (int r = 0; r < 3; r++)
            run_layer(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 3)), int'($urandom_range(1, 20)),
                      int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
                      int'($urandom_range(1, 3)), 70, "rnd");

        // Zero field rejected
        start_layer(1, 1, 0, 8, 4, 4, 1);
        chk("t5_cfg_err_pulse", 128'(cfg_err), 128'(1));
        seen = 0;
        @(negedge clk);
        chk("t5_cfg_err_low", 128'(cfg_err), 128'(0));
        chk("t5_busy_low", 128'(busy), 128'(0));
        repeat (4) begin
            seen |= bus.op_valid;
            @(negedge clk);
        end
        chk("t5_no_op_valid", 128'(seen), 128'(0));

        // Abort mid-ISSUE
        bus.op_ready = 1'b1; bus.wb_ready = 1'b1;
        start_layer(2, 3, 3, 8, 4, 4, 2);
        repeat (4) @(negedge clk);
        chk("t6_in_issue", 128'(bus.op_valid), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort_idle", 128'({busy, done, bus.op_valid, bus.wb_valid}), 128'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= done | bus.op_valid;
        end
        chk("t6_abort_quiet", 128'(seen), 128'(0));

        // Async reset mid-ISSUE
        start_layer(2, 3, 3, 8, 4, 4, 2);
        repeat (3) @(negedge clk);
        chk("t6_in_issue2", 128'(bus.op_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", 128'({busy, done, cfg_err, bus.op_valid, bus.wb_valid,
                                      cur_beat(), perf_stall}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_layer(1, 1, 1, 8, 4, 4, 1, 100, "t6_rerun");
        chk("t6_rerun_beats", 128'(obs_q.size()), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
